axis_pkt_capture: RTL

AXI-Stream slave that captures whole packets into a multi-slot byte buffer for the router's packet-processing logic. It generalises the single-buffer capture block with a configurable bus width, slot count and buffer depth. It adds sparse-tkeep byte packing, overflow truncation, a flush that discards the in-flight packet, and a byte-addressed read port with per-packet release. Slots form a ring: the writer fills the next free slot, and the consumer reads and releases the oldest committed slot.

---
 rtl/axis_pkt_capture.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/axis_pkt_capture.sv
// ---------------------------------------------------------------------------
// axis_pkt_capture
//
// AXI-Stream slave that captures whole packets into a ring of byte-wide
// packet slots. The writer packs the kept bytes of each beat (any tkeep
// pattern) into consecutive slot addresses. It truncates packets that
// exceed BUF_BYTES and commits a slot on tlast. The consumer reads the
// oldest committed slot through a byte-addressed port with one cycle of
// latency. It then releases the slot with pkt_release. A rising edge on
// flush empties the ring and drops the rest of any packet in flight.
//
// Ports
//   aclk, aresetn   clock, asynchronous active-low reset
//   s_axis_*        AXI-Stream slave (tdata, tkeep, tvalid, tlast, tready)
//   flush           level input; its rising edge flushes the ring
//   pkt_valid       at least one committed packet is available
//   pkt_len         byte length of the oldest committed packet
//   pkt_trunc       oldest committed packet overflowed its slot
//   rd_addr         byte address within the oldest committed slot
//   rd_data         byte at rd_addr, registered (one-cycle latency)
//   pkt_release     frees the oldest committed slot (ignored when empty)
//   slots_used      number of committed slots
// ---------------------------------------------------------------------------
module axis_pkt_capture #(
    parameter int DATA_BYTES = 4,
    parameter int BUF_BYTES  = 1024,
    parameter int ADDR_W     = 16,
    parameter int NUM_SLOTS  = 2
) (
    input  logic                         aclk,
    input  logic                         aresetn,

    input  logic [8*DATA_BYTES-1:0]      s_axis_tdata,
    input  logic [DATA_BYTES-1:0]        s_axis_tkeep,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,

    input  logic                         flush,

    output logic                         pkt_valid,
    output logic [ADDR_W-1:0]            pkt_len,
    output logic                         pkt_trunc,
    input  logic [ADDR_W-1:0]            rd_addr,
    output logic [7:0]                   rd_data,
    input  logic                         pkt_release,
    output logic [$clog2(NUM_SLOTS+1)-1:0] slots_used
);

    // -----------------------------------------------------------------------
    // Derived widths and constants
    // -----------------------------------------------------------------------
    localparam int KW    = $clog2(DATA_BYTES + 1);
    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int BW    = (BUF_BYTES > 1) ? $clog2(BUF_BYTES) : 1;
    localparam int SU_W  = $clog2(NUM_SLOTS + 1);

    // Capacity in the widened (ADDR_W+1) domain used for overflow compares.
    localparam logic [ADDR_W:0]   BUF_LIM  = (ADDR_W+1)'(BUF_BYTES);
    localparam logic [ADDR_W-1:0] BUF_FULL = ADDR_W'(BUF_BYTES);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_CAPTURE  = 2'd1;
    localparam logic [1:0] ST_OVERFLOW = 2'd2;
    localparam logic [1:0] ST_DISCARD  = 2'd3;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]        state_q,      state_d;
    logic [ADDR_W-1:0] wr_len_q,     wr_len_d;
    logic              trunc_q,      trunc_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [SU_W-1:0]   slots_used_q, slots_used_d;
    logic              flush_q,      flush_d;
    logic [7:0]        rd_data_q,    rd_data_d;

    // Per-slot metadata recorded at commit.
    logic [ADDR_W-1:0] slot_len_q   [NUM_SLOTS];
    logic [ADDR_W-1:0] slot_len_d   [NUM_SLOTS];
    logic              slot_trunc_q [NUM_SLOTS];
    logic              slot_trunc_d [NUM_SLOTS];

    // Packet byte storage, one BUF_BYTES region per slot.
    logic [7:0] buf_mem [NUM_SLOTS][BUF_BYTES];

    // -----------------------------------------------------------------------
    // Handshake and flush edge detect
    // -----------------------------------------------------------------------
    logic flush_rise;
    logic beat_acc;
    logic capturing;

    assign flush_d    = flush;
    assign flush_rise = flush && !flush_q;

    // A new packet may only start when a free slot exists. Once started it
    // owns that slot, so every later state accepts unconditionally.
    // tready is held low while reset is asserted.
    assign s_axis_tready = aresetn &&
                           ((state_q != ST_IDLE) || (slots_used_q < SU_W'(NUM_SLOTS)));
    assign beat_acc      = s_axis_tvalid && s_axis_tready;
    assign capturing     = (state_q == ST_IDLE) || (state_q == ST_CAPTURE);

    // -----------------------------------------------------------------------
    // Byte packing: lane i lands at wr_len + (number of kept lanes below i).
    // Lanes whose packed position falls beyond the slot are not written.
    // -----------------------------------------------------------------------
    logic [KW-1:0]        keep_cnt;
    logic [ADDR_W:0]      lane_off;
    logic [DATA_BYTES-1:0] lane_fit;
    logic [BW-1:0]        lane_addr [DATA_BYTES];
    logic [ADDR_W:0]      sum_len;
    logic                 over;
    logic [ADDR_W-1:0]    new_len;

    // NOTE: every variable assigned in an always_comb gets a default before
    // any conditional logic, otherwise paths that skip it infer a latch.
    always_comb begin
        keep_cnt = '0;
        lane_off = '0;
        lane_fit = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            lane_off     = {1'b0, wr_len_q} + (ADDR_W+1)'(keep_cnt);
            lane_fit[i]  = s_axis_tkeep[i] && (lane_off < BUF_LIM);
            lane_addr[i] = BW'(lane_off);
            keep_cnt     = keep_cnt + KW'(s_axis_tkeep[i]);
        end
        // Compare is one bit wider than a length so it cannot wrap.
        sum_len = {1'b0, wr_len_q} + (ADDR_W+1)'(keep_cnt);
        over    = (sum_len > BUF_LIM);
        new_len = over ? BUF_FULL : sum_len[ADDR_W-1:0];
    end

    // NOTE: the packet buffer has no reset; its contents are only ever read
    // below the committed length, so stale bytes are never observed.
    always_ff @(posedge aclk) begin
        if (beat_acc && capturing && !flush_rise) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                if (lane_fit[i]) begin
                    buf_mem[wr_ptr_q][lane_addr[i]] <= s_axis_tdata[8*i +: 8];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Ring pointer increment, modulo NUM_SLOTS
    // -----------------------------------------------------------------------
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + 1'b1;
    endfunction

    // -----------------------------------------------------------------------
    // Capture FSM, commit and release bookkeeping
    // -----------------------------------------------------------------------
    logic do_commit;
    logic rel_fire;

    always_comb begin
        state_d      = state_q;
        wr_len_d     = wr_len_q;
        trunc_d      = trunc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        slots_used_d = slots_used_q;
        slot_len_d   = slot_len_q;
        slot_trunc_d = slot_trunc_q;
        do_commit    = 1'b0;
        rel_fire     = pkt_release && (slots_used_q != '0);

        if (flush_rise) begin
            // Flush wins over commit and release. The committed slots are
            // abandoned by moving the read side up to the write side.
            slots_used_d = '0;
            rd_ptr_d     = wr_ptr_q;
            wr_len_d     = '0;
            trunc_d      = 1'b0;
            if (beat_acc) begin
                // The beat taken this cycle is dropped; if it was not the
                // last beat, the rest of its packet must be dropped too.
                state_d = s_axis_tlast ? ST_IDLE : ST_DISCARD;
            end else if ((state_q == ST_CAPTURE) || (state_q == ST_OVERFLOW)) begin
                state_d = ST_DISCARD;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_CAPTURE: begin
                    if (beat_acc) begin
                        if (s_axis_tlast) begin
                            // An all-empty packet leaves no trace.
                            do_commit = (new_len != '0);
                            wr_len_d  = '0;
                            trunc_d   = 1'b0;
                            state_d   = ST_IDLE;
                        end else begin
                            wr_len_d = new_len;
                            trunc_d  = trunc_q || over;
                            state_d  = over ? ST_OVERFLOW : ST_CAPTURE;
                        end
                    end
                end
                ST_OVERFLOW: begin
                    // wr_len is already BUF_BYTES, so new_len stays there.
                    if (beat_acc && s_axis_tlast) begin
                        do_commit = 1'b1;
                        wr_len_d  = '0;
                        trunc_d   = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (beat_acc && s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (do_commit) begin
                slot_len_d[wr_ptr_q]   = new_len;
                slot_trunc_d[wr_ptr_q] = trunc_q || over;
                wr_ptr_d               = ptr_inc(wr_ptr_q);
            end
            if (rel_fire) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            // Commit and release together leave the count unchanged.
            case ({do_commit, rel_fire})
                2'b10:   slots_used_d = slots_used_q + 1'b1;
                2'b01:   slots_used_d = slots_used_q - 1'b1;
                default: slots_used_d = slots_used_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Consumer read port
    // -----------------------------------------------------------------------
    assign pkt_valid  = (slots_used_q != '0);
    assign pkt_len    = slot_len_q[rd_ptr_q];
    assign pkt_trunc  = slot_trunc_q[rd_ptr_q];
    assign slots_used = slots_used_q;
    assign rd_data    = rd_data_q;

    // Bytes at or beyond the packet length read as zero; the address is only
    // narrowed to the slot index width after that bound has been checked.
    always_comb begin
        rd_data_d = 8'h00;
        if (rd_addr < pkt_len) begin
            rd_data_d = buf_mem[rd_ptr_q][BW'(rd_addr)];
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from the same clock edge, independent of order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            wr_len_q     <= '0;
            trunc_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            slots_used_q <= '0;
            flush_q      <= 1'b0;
            rd_data_q    <= 8'h00;
            slot_len_q   <= '{default: '0};
            slot_trunc_q <= '{default: 1'b0};
        end else begin
            state_q      <= state_d;
            wr_len_q     <= wr_len_d;
            trunc_q      <= trunc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            slots_used_q <= slots_used_d;
            flush_q      <= flush_d;
            rd_data_q    <= rd_data_d;
            slot_len_q   <= slot_len_d;
            slot_trunc_q <= slot_trunc_d;
        end
    end

endmodule
